// File: rtl/game_state_gen2.sv
// game_state_gen2: up/down game counter with win/loss scoring and a
// three-state IDLE/RUN/OVER controller. Reaching all-ones scores a win,
// reaching zero scores a loss; the game ends when either score hits
// WIN_LIMIT.
// Optional feature: define GAME_TIMEOUT_EN to end a game (who = 11) after
// TIMEOUT_CYCLES un-held RUN cycles without a score end.
module game_state_gen2 #(
    parameter int COUNTER_SIZE   = 4,
    parameter int SCORE_SIZE     = 4,
    parameter int WIN_LIMIT      = 15,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              control,
    input  logic [COUNTER_SIZE-1:0] i_value,
    input  logic                    INIT,
    input  logic                    hold,
    output logic [COUNTER_SIZE-1:0] count,
    output logic                    win,
    output logic                    los,
    output logic [SCORE_SIZE-1:0]   win_score,
    output logic [SCORE_SIZE-1:0]   los_score,
    output logic [1:0]              who,
    output logic                    gameover
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    localparam logic [SCORE_SIZE-1:0] LIMIT_LAST = SCORE_SIZE'(WIN_LIMIT - 1);

    logic [1:0]              state;
    logic [COUNTER_SIZE-1:0] count_next;
    logic                    advance;
    logic                    win_hit;
    logic                    los_hit;
    logic                    timeout_hit;

    // Next counter value for the selected step mode (modulo 2^COUNTER_SIZE)
    always_comb begin
        count_next = count;
        case (control)
            2'd0: count_next = count + COUNTER_SIZE'(1);
            2'd1: count_next = count + COUNTER_SIZE'(2);
            2'd2: count_next = count - COUNTER_SIZE'(1);
            2'd3: count_next = count - COUNTER_SIZE'(2);
            default: count_next = count;
        endcase
    end

    // Flags and game-end detection from the registered count and state
    always_comb begin
        win      = (state == RUN) && (count == '1);
        los      = (state == RUN) && (count == '0);
        gameover = (state == OVER);
        advance  = (state == RUN) && !hold;
        win_hit  = advance && win && (win_score == LIMIT_LAST);
        los_hit  = advance && los && (los_score == LIMIT_LAST);
    end

`ifdef GAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;

    assign timeout_hit = advance && (timer == TW'(TIMEOUT_CYCLES - 1));

    // Per-game budget of un-held RUN cycles
    always_ff @(posedge clk) begin
        if (reset || INIT) begin
            timer <= '0;
        end else if (advance) begin
            timer <= timer + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Game state, counter and scores; score end takes precedence over timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            win_score <= '0;
            los_score <= '0;
            who       <= 2'b00;
        end else if (INIT) begin
            state     <= RUN;
            count     <= i_value;
            win_score <= '0;
            los_score <= '0;
            who       <= 2'b00;
        end else if (advance) begin
            if (win) begin
                win_score <= win_score + SCORE_SIZE'(1);
            end
            if (los) begin
                los_score <= los_score + SCORE_SIZE'(1);
            end
            // The counter keeps the scoring value on the edge that ends the game
            if (win_hit) begin
                state <= OVER;
                who   <= 2'b10;
            end else if (los_hit) begin
                state <= OVER;
                who   <= 2'b01;
            end else begin
                count <= count_next;
                if (timeout_hit) begin
                    state <= OVER;
                    who   <= 2'b11;
                end
            end
        end
    end

endmodule
